mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single Mem port (rd/wr/addr/wr_data, mem_ready, rd_data, rd_data_valid) between two requesters:
//  instruction fetch (IF) and data load/store (DM). Sequences each access as issue -> wait -> respond, one access in flight.
//  Sits between Control/Memory stage logic and Mem; its busy output feeds freeze_cpu.
// PARAMETERS
//  ADDR_W      32   address width
//  DATA_W      32   data width
//  RD_TIMEOUT  64   max cycles in WAIT_RD before read is aborted with error (>=2)
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  rst          in   1       synchronous reset, active-high
//  if_req       in   1       IF read request, level, held until if_valid
//  if_addr      in   ADDR_W  IF read address
//  if_gnt       out  1       1-cycle pulse: IF request accepted, address latched
//  if_valid     out  1       1-cycle pulse: if_rd_data valid
//  if_rd_data   out  DATA_W  IF read data
//  dm_req       in   1       DM request, level, held until dm_valid
//  dm_wr        in   1       1 = write, 0 = read
//  dm_addr      in   ADDR_W  DM address
//  dm_wr_data   in   DATA_W  DM write data
//  dm_gnt       out  1       1-cycle pulse: DM request accepted
//  dm_valid     out  1       1-cycle pulse: DM read data valid / write done
//  dm_rd_data   out  DATA_W  DM read data
//  err          out  1       1-cycle pulse together with x_valid when that read timed out
//  busy         out  1       1 whenever state != IDLE
//  mem_rd       out  1       Mem read strobe, 1 cycle, only when mem_ready
//  mem_wr       out  1       Mem write strobe, 1 cycle, only when mem_ready
//  mem_addr     out  ADDR_W  Mem address (latched)
//  mem_wr_data  out  DATA_W  Mem write data (latched)
//  mem_ready    in   1       Mem can accept a strobe this cycle
//  mem_rd_data  in   DATA_W  Mem read data
//  mem_rd_valid in   1       Mem read data valid pulse
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; timeout counter, stale flag, priority pointer cleared. Reset mid-access abandons it.
//  FSM: IDLE -> ISSUE -> (WAIT_RD | IDLE) ; WAIT_RD -> IDLE.
//  IDLE: if any req: grant one, pulse x_gnt, latch addr/wr/wr_data/owner, go ISSUE (x_gnt cycle N).
//  ISSUE: while !mem_ready hold, strobes 0. When mem_ready: assert mem_rd or mem_wr for exactly that cycle.
//   Write: pulse dm_valid next cycle, go IDLE. Read: clear counter, go WAIT_RD. Earliest strobe = N+1.
//  WAIT_RD: on mem_rd_valid at cycle M: capture mem_rd_data, owner x_valid=1 and x_rd_data at M+1, go IDLE.
//   Counter increments per cycle; on reaching RD_TIMEOUT: x_valid=1, x_rd_data=0, err=1, set stale, go IDLE.
//  Stale flag: first mem_rd_valid seen while stale=1 is discarded and clears stale; ISSUE for a read waits while stale=1.
//  mem_rd_valid outside WAIT_RD with stale=0 is ignored.
//  Priority (default): DM over IF when both req in IDLE. A request arriving during busy waits; no request is dropped.
//  x_rd_data holds last value between valids. Never more than one strobe outstanding; mem_rd & mem_wr never both 1.
//  IF requests are always reads; if_req ignored while IF owns the in-flight access (no re-grant before if_valid).
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin; after a grant to X, the other requester wins the next simultaneous tie.
//   Pointer reset selects DM first.
//  MEM_ARB_RR_EN undefined: fixed DM-over-IF priority; IF may starve under back-to-back DM traffic.
// TESTING
//  1 IF read 0x100, mem_ready=1, Mem returns 0xDEADBEEF 3 cyc after mem_rd -> if_gnt@N, mem_rd@N+1, if_valid+data@N+5.
//  2 DM write 0x20<-0x12345678, mem_ready low 4 cyc -> mem_wr single pulse on first ready cycle, dm_valid next cycle, busy low after.
//  3 if_req & dm_req same cycle, both reads -> dm granted first, IF granted the cycle after dm_valid; RR build: second tie goes IF.
//  4 Read with no mem_rd_valid -> at RD_TIMEOUT: x_valid=1, data=0, err=1; next read waits for stale valid, gets its own data.
//  5 rst asserted in WAIT_RD -> next cycle IDLE, all outputs 0; late mem_rd_valid produces no x_valid.
//  6 Random IF/DM traffic vs reference model -> every req gets exactly one gnt and one valid, data matches, strobes never overlap.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF) and data (DM)
// requesters with one access in flight. Define MEM_ARB_RR_EN for round-robin tie-breaking.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rd_data,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wr_data,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rd_data,
  output logic              err,
  output logic              busy,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_valid
);

  // state   | meaning
  // IDLE    | nothing in flight; may grant a requester
  // ISSUE   | access latched; waiting for mem_ready (reads also wait for stale clear)
  // WAIT_RD | read strobed; waiting for mem_rd_valid or the read timeout
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(RD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                owner_dm_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                stale_q;
  logic                if_valid_q, dm_valid_q, err_q;
  logic [DATA_W-1:0]   if_data_q, dm_data_q;

  logic                resp_cycle;
  logic                dm_first;
  logic                grant_if, grant_dm;
  logic                strobe_rd, strobe_wr;
  logic                rd_done, rd_timeout;

  // A response pulse is out this cycle and its requester still holds req; no grant now.
  assign resp_cycle = if_valid_q | dm_valid_q;

`ifdef MEM_ARB_RR_EN
  logic ptr_if_q;

  assign dm_first = !if_req || !ptr_if_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_if_q <= 1'b0;
    end else if (grant_dm) begin
      ptr_if_q <= 1'b1;
    end else if (grant_if) begin
      ptr_if_q <= 1'b0;
    end
  end
`else
  assign dm_first = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;
    strobe_rd  = 1'b0;
    strobe_wr  = 1'b0;
    rd_done    = 1'b0;
    rd_timeout = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (!resp_cycle) begin
            grant_dm = dm_req && dm_first;
            grant_if = if_req && !grant_dm;
            if (grant_dm || grant_if) begin
              state_d = ISSUE;
            end
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            if (wr_q) begin
              strobe_wr = 1'b1;
              state_d   = IDLE;
            end else if (!stale_q) begin
              strobe_rd = 1'b1;
              state_d   = WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (mem_rd_valid) begin
            rd_done = 1'b1;
            state_d = IDLE;
          end else if (cnt_q == '0) begin
            rd_timeout = 1'b1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_dm_q <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      stale_q    <= 1'b0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      err_q      <= 1'b0;
      if_data_q  <= '0;
      dm_data_q  <= '0;
    end else begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      err_q      <= 1'b0;

      if (grant_dm || grant_if) begin
        owner_dm_q <= grant_dm;
        wr_q       <= grant_dm && dm_wr;
        addr_q     <= grant_dm ? dm_addr : if_addr;
        if (grant_dm) begin
          wdata_q <= dm_wr_data;
        end
      end

      if (strobe_rd) begin
        cnt_q <= CNT_LOAD;
      end else if (state_q == WAIT_RD && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (strobe_wr) begin
        dm_valid_q <= 1'b1;
      end

      if (rd_done || rd_timeout) begin
        err_q <= rd_timeout;
        if (owner_dm_q) begin
          dm_valid_q <= 1'b1;
          dm_data_q  <= rd_done ? mem_rd_data : '0;
        end else begin
          if_valid_q <= 1'b1;
          if_data_q  <= rd_done ? mem_rd_data : '0;
        end
      end

      // After a timeout the abandoned read may still answer; swallow that one valid.
      if (rd_timeout) begin
        stale_q <= 1'b1;
      end else if (stale_q && mem_rd_valid) begin
        stale_q <= 1'b0;
      end
    end
  end

  assign if_gnt      = grant_if;
  assign dm_gnt      = grant_dm;
  assign mem_rd      = strobe_rd;
  assign mem_wr      = strobe_wr;
  assign busy        = (state_q != IDLE);
  assign mem_addr    = addr_q;
  assign mem_wr_data = wdata_q;
  assign if_valid    = if_valid_q;
  assign dm_valid    = dm_valid_q;
  assign err         = err_q;
  assign if_rd_data  = if_data_q;
  assign dm_rd_data  = dm_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus random traffic, compared every cycle against
// a transaction-level model of the arbiter driven by a simple memory responder.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RT = 8;

  logic clk = 1'b0;
  logic rst;
  logic if_req, if_gnt, if_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rd_data;
  logic dm_req, dm_wr, dm_gnt, dm_valid;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wr_data, dm_rd_data;
  logic err, busy, mem_rd, mem_wr, mem_ready, mem_rd_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data, mem_rd_data;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(RT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rd_data(if_rd_data),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wr_data(dm_wr_data),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rd_data(dm_rd_data),
    .err(err), .busy(busy), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_ready(mem_ready), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid)
  );

  typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } op_t;
  typedef struct { int due; logic [31:0] data; } rsp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  op_t  if_q[$], dm_q[$];
  rsp_t rsp_q[$];
  logic [31:0] mem_arr [256];
  int lat = 3, rnd_lat = 0, ready_pct = 100, lo_from = -1, lo_to = -1;
  bit drop = 0;
  int if_gnt_log[$], dm_gnt_log[$], if_val_log[$], dm_val_log[$], mem_rd_log[$], mem_wr_log[$];

  // model of the arbiter in transaction terms
  bit m_inflight, m_dm, m_wr, m_issued, m_stale, m_ifv, m_dmv, m_err, m_ptr_if;
  logic [31:0] m_addr, m_wdata, m_if_data, m_dm_data;
  int m_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_inflight = 0; m_dm = 0; m_wr = 0; m_issued = 0; m_stale = 0;
    m_ifv = 0; m_dmv = 0; m_err = 0; m_ptr_if = 0; m_wait = 0;
    m_addr = '0; m_wdata = '0; m_if_data = '0; m_dm_data = '0;
  endtask

  task automatic deliver(input logic [31:0] d, input bit e);
    m_inflight = 0;
    m_err = e;
    if (m_dm) begin m_dmv = 1; m_dm_data = d; end
    else begin m_ifv = 1; m_if_data = d; end
  endtask

  task automatic clear_logs();
    if_gnt_log.delete(); dm_gnt_log.delete(); if_val_log.delete();
    dm_val_log.delete(); mem_rd_log.delete(); mem_wr_log.delete();
  endtask

  task automatic tick();
    bit e_if_gnt, e_dm_gnt, e_rd, e_wr, pick_dm;
    int l;
    @(negedge clk);
    cyc++;
    // requesters hold req until their valid, then move to the next queued op
    if (!rst) begin
      if (if_req && if_valid) begin if_req = 0; void'(if_q.pop_front()); end
      else if (!if_req && if_q.size() > 0) begin if_req = 1; if_addr = if_q[0].addr; end
      if (dm_req && dm_valid) begin dm_req = 0; void'(dm_q.pop_front()); end
      else if (!dm_req && dm_q.size() > 0) begin
        dm_req = 1; dm_wr = dm_q[0].wr; dm_addr = dm_q[0].addr; dm_wr_data = dm_q[0].data;
      end
    end
    mem_ready = !(cyc >= lo_from && cyc < lo_to) && ($urandom_range(0, 99) < ready_pct);
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      mem_rd_valid = 1; mem_rd_data = rsp_q[0].data; void'(rsp_q.pop_front());
    end else begin
      mem_rd_valid = 0; mem_rd_data = $urandom;
    end
    #1;
`ifdef MEM_ARB_RR_EN
    pick_dm = dm_req && (!if_req || !m_ptr_if);
`else
    pick_dm = dm_req;
`endif
    e_dm_gnt = !m_inflight && !m_ifv && !m_dmv && pick_dm;
    e_if_gnt = !m_inflight && !m_ifv && !m_dmv && if_req && !pick_dm;
    e_rd = m_inflight && !m_issued && !m_wr && mem_ready && !m_stale;
    e_wr = m_inflight && !m_issued && m_wr && mem_ready;
    if (!rst) begin
      chk("if_gnt", 32'(if_gnt), 32'(e_if_gnt));
      chk("dm_gnt", 32'(dm_gnt), 32'(e_dm_gnt));
      chk("mem_rd", 32'(mem_rd), 32'(e_rd));
      chk("mem_wr", 32'(mem_wr), 32'(e_wr));
      chk("strobe_overlap", 32'(mem_rd & mem_wr), 32'd0);
      chk("if_valid", 32'(if_valid), 32'(m_ifv));
      chk("dm_valid", 32'(dm_valid), 32'(m_dmv));
      chk("err", 32'(err), 32'(m_err));
      chk("busy", 32'(busy), 32'(m_inflight));
      chk("if_rd_data", if_rd_data, m_if_data);
      chk("dm_rd_data", dm_rd_data, m_dm_data);
      if (m_inflight) chk("mem_addr", mem_addr, m_addr);
      if (m_inflight && m_wr) chk("mem_wr_data", mem_wr_data, m_wdata);
      if (if_gnt) if_gnt_log.push_back(cyc);
      if (dm_gnt) dm_gnt_log.push_back(cyc);
      if (if_valid) if_val_log.push_back(cyc);
      if (dm_valid) dm_val_log.push_back(cyc);
    end
    if (mem_wr) begin mem_arr[mem_addr[9:2]] = mem_wr_data; mem_wr_log.push_back(cyc); end
    if (mem_rd) begin
      mem_rd_log.push_back(cyc);
      l = rnd_lat ? $urandom_range(1, 4) : lat;
      if (!drop) rsp_q.push_back('{cyc + l, mem_arr[mem_addr[9:2]]});
    end
    if (rst) model_reset();
    else begin
      m_ifv = 0; m_dmv = 0; m_err = 0;
      if (m_stale && mem_rd_valid) m_stale = 0;
      if (e_if_gnt || e_dm_gnt) begin
        m_inflight = 1; m_dm = e_dm_gnt; m_wr = e_dm_gnt && dm_wr; m_issued = 0;
        m_addr = e_dm_gnt ? dm_addr : if_addr;
        if (e_dm_gnt) m_wdata = dm_wr_data;
        m_ptr_if = e_dm_gnt;
      end else if (e_wr) begin
        m_inflight = 0; m_dmv = 1;
      end else if (e_rd) begin
        m_issued = 1; m_wait = 0;
      end else if (m_inflight && m_issued) begin
        if (mem_rd_valid) deliver(mem_rd_data, 0);
        else begin
          m_wait++;
          if (m_wait == RT) begin deliver('0, 1); m_stale = 1; end
        end
      end
    end
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(if_q.size() == 0 && dm_q.size() == 0 && !if_req && !dm_req) && n < max_cyc);
    if (n >= max_cyc) begin
      checks++; errors++;
      $display("FAIL wait_bound cyc=%0d got=%0d cycles exp=<%0d", cyc, n, max_cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1; if_req = 0; dm_req = 0; if_q.delete(); dm_q.delete();
    tick();
    rst = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, stale_due;
    rst = 1; if_req = 0; if_addr = '0; dm_req = 0; dm_wr = 0; dm_addr = '0; dm_wr_data = '0;
    mem_ready = 0; mem_rd_valid = 0; mem_rd_data = '0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h5A00_0000 + 32'(i) * 32'h101;
    mem_arr[64] = 32'hDEAD_BEEF;
    model_reset();
    repeat (2) tick();
    rst = 0;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wr_data", mem_wr_data, 32'd0);
    chk("rst_if_rd_data", if_rd_data, 32'd0);

    // 1: IF read, immediate ready, 3-cycle memory latency
    clear_logs();
    if_q.push_back('{1'b0, 32'h100, 32'h0});
    run_until_idle(40);
    chk("t1_gnt_to_rd", 32'(mem_rd_log[0] - if_gnt_log[0]), 32'd1);
    chk("t1_gnt_to_valid", 32'(if_val_log[0] - if_gnt_log[0]), 32'd5);
    chk("t1_data", if_rd_data, 32'hDEAD_BEEF);

    // 2: DM write with mem_ready low for 4 cycles after the grant
    clear_logs();
    lo_from = cyc + 2; lo_to = cyc + 6;
    dm_q.push_back('{1'b1, 32'h20, 32'h1234_5678});
    run_until_idle(40);
    chk("t2_wr_count", 32'(mem_wr_log.size()), 32'd1);
    chk("t2_gnt_to_wr", 32'(mem_wr_log[0] - dm_gnt_log[0]), 32'd5);
    chk("t2_wr_to_valid", 32'(dm_val_log[0] - mem_wr_log[0]), 32'd1);
    chk("t2_mem_written", mem_arr[8], 32'h1234_5678);
    chk("t2_busy_after", 32'(busy), 32'd0);

    // 3: simultaneous reads, then a tie with DM back-to-back
    do_reset();
    clear_logs();
    t0 = cyc;
    dm_q.push_back('{1'b0, 32'h10, 32'h0});
    if_q.push_back('{1'b0, 32'h14, 32'h0});
    run_until_idle(60);
    chk("t3_dm_gnt_first", 32'(dm_gnt_log[0]), 32'(t0 + 1));
    chk("t3_if_after_dmv", 32'(if_gnt_log[0] - dm_val_log[0]), 32'd1);
    chk("t3_if_data", if_rd_data, mem_arr[5]);
    clear_logs();
    dm_q.push_back('{1'b0, 32'h18, 32'h0});
    dm_q.push_back('{1'b0, 32'h1c, 32'h0});
    if_q.push_back('{1'b0, 32'h24, 32'h0});
    run_until_idle(80);
`ifdef MEM_ARB_RR_EN
    chk("t3_rr_tie2_if", 32'(if_gnt_log[0]), 32'(dm_val_log[0] + 1));
`else
    chk("t3_fixed_tie2_dm", 32'(dm_gnt_log[1]), 32'(dm_val_log[0] + 1));
`endif

    // 4: read timeout, then a read that must wait out the stale response
    clear_logs();
    drop = 1;
    if_q.push_back('{1'b0, 32'h40, 32'h0});
    run_until_idle(60);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_data_zero", if_rd_data, 32'd0);
    chk("t4_latency", 32'(if_val_log[0] - mem_rd_log[0]), 32'(RT + 1));
    drop = 0;
    stale_due = cyc + 6;
    rsp_q.push_back('{stale_due, 32'hBAD0_BAD0});
    clear_logs();
    dm_q.push_back('{1'b0, 32'h44, 32'h0});
    run_until_idle(60);
    chk("t4_rd_after_stale", 32'(mem_rd_log[0]), 32'(stale_due + 1));
    chk("t4_own_data", dm_rd_data, mem_arr[17]);
    chk("t4_no_err", 32'(err), 32'd0);

    // 5: reset while waiting for read data
    clear_logs();
    lat = 6;
    if_q.push_back('{1'b0, 32'h80, 32'h0});
    for (int i = 0; i < 20 && mem_rd_log.size() == 0; i++) tick();
    chk("t5_read_issued", 32'(mem_rd_log.size()), 32'd1);
    repeat (2) tick();
    do_reset();
    tick();
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_if_valid", 32'(if_valid), 32'd0);
    chk("t5_mem_addr", mem_addr, 32'd0);
    chk("t5_if_rd_data", if_rd_data, 32'd0);
    repeat (8) tick();
    chk("t5_no_late_valid", 32'(if_val_log.size()), 32'd0);
    lat = 3;

    // 6: random traffic
    clear_logs();
    rnd_lat = 1; ready_pct = 70;
    for (int i = 0; i < 25; i++) begin
      if_q.push_back('{1'b0, {22'd0, 8'($urandom_range(0, 255)), 2'b00}, 32'h0});
      dm_q.push_back('{1'($urandom_range(0, 1)), {22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom});
    end
    run_until_idle(3000);
    chk("t6_if_gnts", 32'(if_gnt_log.size()), 32'd25);
    chk("t6_if_valids", 32'(if_val_log.size()), 32'd25);
    chk("t6_dm_gnts", 32'(dm_gnt_log.size()), 32'd25);
    chk("t6_dm_valids", 32'(dm_val_log.size()), 32'd25);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
